bcd2num: RTL

Sequential BCD-to-binary converter for the Lab7 PS/2 keyboard datapath. It is the inverse of the binary-to-BCD display path: packed decimal digits from keypad entry are turned back into a binary value for the arithmetic and scan-code logic. The conversion uses the reverse double-dabble method, one iteration per clock, under a start/valid handshake. It rejects any input that contains a non-decimal digit.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_sub3.sv | 16 +
 rtl/bcd2num.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Width of one packed decimal digit.
  localparam int DIGIT_W = 4;

  // Largest legal decimal digit.
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // Correction applied to a digit that received a carry-in bit from above.
  localparam logic [DIGIT_W-1:0] BCD_ADJ = 4'd3;

  // 10^n as an unsigned 64-bit value.
  // Used at elaboration time to size-check the binary result.
  function automatic longint unsigned pow10(input int n);
    longint unsigned acc;
    acc = 64'd1;
    for (int k = 0; k < n; k++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bcd_sub3.sv
// One digit of the reverse double-dabble correction.
// A digit of 8 or more has just taken the bit shifted down from the next
// digit, which counts as 8 here but is only worth 5 in decimal, so 3 is
// removed.
module bcd_sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  localparam logic [DIGIT_W-1:0] ADJ_THRESHOLD = 4'd8;

  assign dout = (din >= ADJ_THRESHOLD) ? (din - BCD_ADJ) : din;

endmodule

// File: rtl/bcd2num.sv
// Sequential packed-BCD to binary converter.
// Uses reverse double-dabble, one shift/correct step per clock, behind a
// start/valid handshake. Inputs that hold a non-decimal digit are rejected
// through the o_err flag.
module bcd2num
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [DIGIT_W*DIGITS-1:0] i_bcd,
  output logic                      o_busy,
  output logic                      o_valid,
  output logic                      o_err,
  output logic [BIN_W-1:0]          o_bin
);

  localparam int BCD_W  = DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  // The largest decimal input must fit in the binary result.
  generate
    if ((longint'(1) << BIN_W) <= (pow10(DIGITS) - 64'd1)) begin : g_width_check
      $error("bcd2num: BIN_W too small to hold 10^DIGITS-1");
    end
  endgenerate

  bcd_state_t        state_reg;
  logic [WORK_W-1:0] work_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy_reg;
  logic              valid_reg;
  logic              err_reg;
  logic [BIN_W-1:0]  bin_reg;

  logic [DIGITS-1:0] digit_bad;
  logic              bcd_bad;
  logic [WORK_W-1:0] shifted;
  logic [BCD_W-1:0]  adj_bcd;
  logic [WORK_W-1:0] step_work;
  logic              last_iter;

  // One comparator per digit; any digit above 9 rejects the request.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_check
      assign digit_bad[gi] = (i_bcd[gi*DIGIT_W +: DIGIT_W] > BCD_MAX);
    end
  endgenerate

  assign bcd_bad = |digit_bad;

  // Each step shifts the whole work register down by one bit.
  // After the shift, every BCD digit is corrected independently.
  assign shifted = work_reg >> 1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
      bcd_sub3 u_sub3 (
        .din  (shifted[BIN_W + gi*DIGIT_W +: DIGIT_W]),
        .dout (adj_bcd[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign step_work = {adj_bcd, shifted[BIN_W-1:0]};
  assign last_iter = (cnt_reg == CNT_W'(BIN_W - 1));

  // Control FSM and datapath.
  // A request is accepted in IDLE and also in DONE, which allows
  // back-to-back conversions.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      bin_reg   <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (i_start) begin
            if (bcd_bad) begin
              err_reg   <= 1'b1;
              bin_reg   <= '0;
              valid_reg <= 1'b1;
              state_reg <= DONE;
            end else begin
              work_reg  <= {i_bcd, {BIN_W{1'b0}}};
              cnt_reg   <= '0;
              err_reg   <= 1'b0;
              busy_reg  <= 1'b1;
              state_reg <= SHIFT;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          work_reg <= step_work;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          if (last_iter) begin
            bin_reg   <= step_work[BIN_W-1:0];
            busy_reg  <= 1'b0;
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Once every bit has been shifted out, the BCD field must have drained
  // to zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state_reg == SHIFT && last_iter) begin
      assert (step_work[WORK_W-1:BIN_W] == '0);
    end
  end

  assign o_busy  = busy_reg;
  assign o_valid = valid_reg;
  assign o_err   = err_reg;
  assign o_bin   = bin_reg;

endmodule
